// File: rtl/buzzer_pkg.sv
// Shared constants, state encoding and width helpers for the buzzer round controller.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package buzzer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_OPEN  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARMED = ST_ARMED,
        OPEN  = ST_OPEN,
        HOLD  = ST_HOLD
    } state_t;

    localparam int DEF_N_PLAYERS   = 4;
    localparam int DEF_ARM_CYCLES  = 16;
    localparam int DEF_OPEN_CYCLES = 64;
    localparam int DEF_HOLD_CYCLES = 32;

    // Bits needed to index v values; never less than one so vectors stay legal.
    function automatic int clog2w(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/buzzer_round_ctrl_if.sv
// Bundles round control inputs and display-facing indicators.
// Latency: n/a (wiring only).
// Backpressure: none; press/start are fire-and-forget pulses.
interface buzzer_round_ctrl_if #(
    parameter int N_PLAYERS = 4
) ();
    localparam int IW = buzzer_pkg::clog2w(N_PLAYERS);

    logic                 start;
    logic [N_PLAYERS-1:0] press;
    logic                 busy;
    logic                 window_open;
    logic                 winner_valid;
    logic [IW-1:0]        winner_id;
    logic                 timeout;
    logic [N_PLAYERS-1:0] false_start;

    modport master (
        output start, press,
        input  busy, window_open, winner_valid, winner_id, timeout, false_start
    );

    modport slave (
        input  start, press,
        output busy, window_open, winner_valid, winner_id, timeout, false_start
    );
endinterface

// File: rtl/press_rr_arbiter.sv
// Round-robin pick among simultaneous requests, starting at ptr and ascending with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to take the grant.
module press_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] grant_idx
);
    // Scan from the farthest offset down to offset 0 so the nearest request to ptr is the last writer.
    always_comb begin
        int idx;
        any       = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                any       = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/buzzer_round_ctrl.sv
// Reaction-round sequencer: arm delay, response window with false-start disqualification, result hold.
// Latency: valid press in an OPEN cycle shows as winner_valid on the next cycle; all outputs registered.
// Backpressure: none; start outside IDLE and presses outside ARMED/OPEN are dropped.
module buzzer_round_ctrl
    import buzzer_pkg::*;
#(
    parameter int N_PLAYERS   = DEF_N_PLAYERS,
    parameter int ARM_CYCLES  = DEF_ARM_CYCLES,
    parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    buzzer_round_ctrl_if.slave  bus
);
    localparam int IW = clog2w(N_PLAYERS);
    localparam int CW = clog2w(max3(ARM_CYCLES, OPEN_CYCLES, HOLD_CYCLES));

    localparam logic [CW-1:0] ARM_LOAD  = CW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_PLAYERS - 1);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        rr_ptr, rr_ptr_n;
    logic                 winner_valid, winner_valid_n;
    logic [IW-1:0]        winner_id, winner_id_n;
    logic                 timeout, timeout_n;
    logic [N_PLAYERS-1:0] false_start, false_start_n;
    logic                 busy, window_open;

    logic [N_PLAYERS-1:0] eligible;
    logic                 arb_any;
    logic [IW-1:0]        arb_idx;

    // Disqualified players cannot compete in the window.
    assign eligible = bus.press & ~false_start;

    press_rr_arbiter #(.N(N_PLAYERS), .IW(IW)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .any       (arb_any),
        .grant_idx (arb_idx)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus next values of the counter, pointer and result registers.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        rr_ptr_n       = rr_ptr;
        winner_valid_n = winner_valid;
        winner_id_n    = winner_id;
        timeout_n      = timeout;
        false_start_n  = false_start;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n        = ARMED;
                    cnt_n          = ARM_LOAD;
                    false_start_n  = '0;
                    winner_valid_n = 1'b0;
                    winner_id_n    = '0;
                    timeout_n      = 1'b0;
                end
            end
            ARMED: begin
                false_start_n = false_start | bus.press;
                if (cnt == '0) begin
                    state_n = OPEN;
                    cnt_n   = OPEN_LOAD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            OPEN: begin
                // A valid press beats expiry, even on the last window cycle.
                if (arb_any) begin
                    state_n        = HOLD;
                    cnt_n          = HOLD_LOAD;
                    winner_valid_n = 1'b1;
                    winner_id_n    = arb_idx;
                    rr_ptr_n       = (arb_idx == LAST_IDX) ? '0 : arb_idx + IW'(1);
                end else if (cnt == '0) begin
                    state_n   = HOLD;
                    cnt_n     = HOLD_LOAD;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n        = IDLE;
                    winner_valid_n = 1'b0;
                    timeout_n      = 1'b0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath registers; busy/window_open are registered from the next state to avoid a cycle of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            rr_ptr       <= '0;
            winner_valid <= 1'b0;
            winner_id    <= '0;
            timeout      <= 1'b0;
            false_start  <= '0;
            busy         <= 1'b0;
            window_open  <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            rr_ptr       <= rr_ptr_n;
            winner_valid <= winner_valid_n;
            winner_id    <= winner_id_n;
            timeout      <= timeout_n;
            false_start  <= false_start_n;
            busy         <= (state_n != IDLE);
            window_open  <= (state_n == OPEN);
        end
    end

    assign bus.busy         = busy;
    assign bus.window_open  = window_open;
    assign bus.winner_valid = winner_valid;
    assign bus.winner_id    = winner_id;
    assign bus.timeout      = timeout;
    assign bus.false_start  = false_start;

endmodule
